// File: rtl/vec_operand_tx.sv
// vec_operand_tx: buffers vector/scalar operand pairs and issues them to vec_mul under a credit cap.
// Optional macro VEC_OPERAND_TX_STATS_EN adds the tx_count fire counter output.
module vec_operand_tx #(
    parameter int SIZE         = 32,
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 12
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [2:0][SIZE-1:0]    in_vec,
    input  logic [SIZE-1:0]         in_scalar,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [2:0][SIZE-1:0]    m_axis_a_tdata,
    output logic                    m_axis_a_tvalid,
    input  logic                    m_axis_a_tready,
    output logic [SIZE-1:0]         m_axis_b_tdata,
    output logic                    m_axis_b_tvalid,
    input  logic                    m_axis_b_tready,
    input  logic                    result_beat,
    output logic [7:0]              inflight,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    credit_err
`ifdef VEC_OPERAND_TX_STATS_EN
    ,
    output logic [31:0]             tx_count
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [7:0] MAX = 8'(MAX_INFLIGHT);
    typedef enum logic {IDLE, PRESENT} state_t;
    state_t state_q;
    logic [4*SIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic [7:0] inflight_q, inflight_d;
    logic err_q;
    logic [2:0][SIZE-1:0] a_q;
    logic [SIZE-1:0] b_q;
    logic push, fire, load;
`ifdef VEC_OPERAND_TX_STATS_EN
    logic [31:0] tx_q;
    assign tx_count = tx_q;
`endif
    assign in_ready = cnt_q != FULL;
    assign push = in_valid && in_ready;
    assign fire = state_q == PRESENT && m_axis_a_tready && m_axis_b_tready;
    // A result arriving with nothing in flight leaves the counter at zero rather than wrapping.
    always_comb inflight_d = (fire && !result_beat) ? inflight_q + 8'd1 :
                             (!fire && result_beat && inflight_q != 8'd0) ? inflight_q - 8'd1 : inflight_q;
    // Loading the output register reserves a credit, so a reload on fire must leave room after this issue.
    always_comb load = cnt_q != '0 && (state_q == IDLE ? inflight_q < MAX : fire && inflight_d < MAX);
    // Operand storage; contents need no reset since pointers and count define validity.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_q] <= {in_vec, in_scalar};
    end
    // Pointers, output register, issue FSM and credit tracking.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
`ifdef VEC_OPERAND_TX_STATS_EN
            tx_q       <= '0;
`endif
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (load) begin
                rd_q <= rd_q + 1'b1;
                a_q  <= mem_q[rd_q][4*SIZE-1:SIZE];
                b_q  <= mem_q[rd_q][SIZE-1:0];
            end
            cnt_q      <= cnt_q + (AW+1)'(push) - (AW+1)'(load);
            state_q    <= load ? PRESENT : fire ? IDLE : state_q;
            inflight_q <= inflight_d;
            err_q      <= err_q || (result_beat && inflight_q == 8'd0);
`ifdef VEC_OPERAND_TX_STATS_EN
            if (fire) tx_q <= tx_q + 32'd1;
`endif
        end
    end
    assign m_axis_a_tdata  = a_q;
    assign m_axis_b_tdata  = b_q;
    assign m_axis_a_tvalid = state_q == PRESENT;
    assign m_axis_b_tvalid = state_q == PRESENT;
    assign inflight        = inflight_q;
    assign fifo_count      = cnt_q;
    assign credit_err      = err_q;
endmodule

// File: tb/tb_vec_operand_tx.sv
// tb_vec_operand_tx: directed checks of vec_operand_tx with a 4-credit limit.
module tb_vec_operand_tx;
    logic aclk = 1'b0, areset = 1'b1;
    logic [2:0][31:0] in_vec = '0;
    logic [31:0] in_scalar = '0;
    logic in_valid = 1'b0, in_ready;
    logic [2:0][31:0] a_tdata;
    logic a_tvalid, a_tready = 1'b0;
    logic [31:0] b_tdata;
    logic b_tvalid, b_tready = 1'b0;
    logic result_beat = 1'b0;
    logic [7:0] inflight;
    logic [3:0] fifo_count;
    logic credit_err;
    int n_vec = 0, n_err = 0;
`ifdef VEC_OPERAND_TX_STATS_EN
    logic [31:0] tx_count;
`endif

    vec_operand_tx #(.SIZE(32), .DEPTH(8), .MAX_INFLIGHT(4)) dut (
        .aclk(aclk), .areset(areset), .in_vec(in_vec), .in_scalar(in_scalar),
        .in_valid(in_valid), .in_ready(in_ready),
        .m_axis_a_tdata(a_tdata), .m_axis_a_tvalid(a_tvalid), .m_axis_a_tready(a_tready),
        .m_axis_b_tdata(b_tdata), .m_axis_b_tvalid(b_tvalid), .m_axis_b_tready(b_tready),
        .result_beat(result_beat), .inflight(inflight), .fifo_count(fifo_count),
        .credit_err(credit_err)
`ifdef VEC_OPERAND_TX_STATS_EN
        , .tx_count(tx_count)
`endif
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0][31:0] pv(input int i);
        return {32'(i * 16 + 2), 32'(i * 16 + 1), 32'(i * 16)};
    endfunction

    function automatic logic [31:0] ps(input int i);
        return 32'(256 + i);
    endfunction

    initial begin
        tick();
        tick();
        areset = 1'b0;
        check("rst_tvalid", a_tvalid, 0);
        check("rst_btvalid", b_tvalid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_count", fifo_count, 0);
        check("rst_inflight", inflight, 0);
        check("rst_err", credit_err, 0);
        check("rst_adata", a_tdata[0], 0);
        check("rst_bdata", b_tdata, 0);

        a_tready = 1'b1;
        b_tready = 1'b1;
        in_vec = {32'h40400000, 32'h40000000, 32'h3F800000};
        in_scalar = 32'h40000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("t1_count", fifo_count, 1);
        check("t1_notyet", a_tvalid, 0);
        tick();
        check("t1_tvalid", a_tvalid, 1);
        check("t1_btvalid", b_tvalid, 1);
        check("t1_a0", a_tdata[0], 32'h3F800000);
        check("t1_a1", a_tdata[1], 32'h40000000);
        check("t1_a2", a_tdata[2], 32'h40400000);
        check("t1_b", b_tdata, 32'h40000000);
        tick();
        check("t1_inflight", inflight, 1);
        check("t1_idle", a_tvalid, 0);
        result_beat = 1'b1;
        tick();
        result_beat = 1'b0;
        check("t1_ret", inflight, 0);

        a_tready = 1'b0;
        b_tready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            in_vec = pv(i);
            in_scalar = ps(i);
            in_valid = 1'b1;
            tick();
        end
        check("t2_full", in_ready, 0);
        check("t2_count", fifo_count, 8);
        check("t2_tvalid", a_tvalid, 1);
        check("t2_head", a_tdata[0], pv(0)[0]);
        in_vec = pv(9);
        in_scalar = ps(9);
        tick();
        in_valid = 1'b0;
        check("t2_refused", fifo_count, 8);
        check("t2_stable_a", a_tdata[2], pv(0)[2]);
        check("t2_stable_b", b_tdata, ps(0));
        check("t2_nofire", inflight, 0);

        a_tready = 1'b1;
        b_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t3_fire_valid", a_tvalid, 1);
            check("t3_fire_data", a_tdata[1], pv(k)[1]);
            check("t3_fire_b", b_tdata, ps(k));
            tick();
        end
        check("t3_stop", a_tvalid, 0);
        check("t3_inflight", inflight, 4);
        check("t3_count", fifo_count, 5);
        tick();
        tick();
        check("t3_hold", a_tvalid, 0);
        check("t3_hold_cnt", fifo_count, 5);
        result_beat = 1'b1;
        tick();
        result_beat = 1'b0;
        check("t3_ret", inflight, 3);
        check("t3_ret_idle", a_tvalid, 0);
        a_tready = 1'b1;
        b_tready = 1'b0;
        tick();
        check("t3_fifth", a_tvalid, 1);
        check("t3_fifth_data", a_tdata[0], pv(4)[0]);

        for (int k = 0; k < 3; k++) begin
            tick();
            check("t4_hold_valid", a_tvalid, 1);
            check("t4_hold_infl", inflight, 3);
            check("t4_hold_data", b_tdata, ps(4));
        end
        a_tready = 1'b0;
        b_tready = 1'b1;
        tick();
        check("t4_bonly", inflight, 3);
        a_tready = 1'b1;
        tick();
        a_tready = 1'b0;
        b_tready = 1'b0;
        check("t4_single", inflight, 4);
        check("t4_idle", a_tvalid, 0);
        check("t4_count", fifo_count, 4);

        result_beat = 1'b1;
        tick();
        result_beat = 1'b0;
        check("t5_dec", inflight, 3);
        tick();
        check("t5_load", a_tvalid, 1);
        check("t5_load_data", a_tdata[0], pv(5)[0]);
        a_tready = 1'b1;
        b_tready = 1'b1;
        result_beat = 1'b1;
        tick();
        a_tready = 1'b0;
        b_tready = 1'b0;
        result_beat = 1'b0;
        check("t5_same", inflight, 3);
        check("t5_reload", a_tvalid, 1);
        check("t5_reload_data", a_tdata[0], pv(6)[0]);
        check("t5_count", fifo_count, 2);

        for (int i = 20; i < 23; i++) begin
            in_vec = pv(i);
            in_scalar = ps(i);
            in_valid = 1'b1;
            tick();
        end
        check("t6_queued", fifo_count, 5);
        a_tready = 1'b1;
        b_tready = 1'b1;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        in_valid = 1'b0;
        a_tready = 1'b0;
        b_tready = 1'b0;
        check("t6_tvalid", a_tvalid, 0);
        check("t6_count", fifo_count, 0);
        check("t6_inflight", inflight, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_err", credit_err, 0);

        result_beat = 1'b1;
        tick();
        result_beat = 1'b0;
        check("t5_err", credit_err, 1);
        check("t5_err_infl", inflight, 0);
        tick();
        check("t5_sticky", credit_err, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
